logicnets_layer_packer: RTL and testbench



---
 rtl/logicnets_layer_packer.sv | 155 +++++++++++++++
 tb/tb_logicnets_layer_packer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logicnets_layer_packer.sv
// ---------------------------------------------------------------------------
// logicnets_layer_packer
//
// Purpose:
//   Gathers the serial per-neuron outputs of one LogicNets layer into a full
//   parallel activation vector for the next layer. Beats arrive in neuron
//   order 0..N_NEURONS-1 and are assembled in a staging register. Finished
//   vectors go into a two-slot buffer, so a stalled consumer does not lose a
//   beat.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   packer can accept a beat (depends on registered state only)
//   M0         one neuron output, OUT_BITS wide
//   in_last    final neuron of a vector (only with LAYER_PACKER_FRAMECHK_EN)
//   out_valid  packed vector available
//   out_ready  downstream accepts the vector
//   M1         packed vector, neuron k at bits [k*OUT_BITS +: OUT_BITS]
//   frame_err  sticky framing error (only with LAYER_PACKER_FRAMECHK_EN)
//
// Configuration macro:
//   LAYER_PACKER_FRAMECHK_EN - adds in_last/frame_err. An early in_last
//   commits a short vector, with the unwritten neurons read as zero.
// ---------------------------------------------------------------------------
module logicnets_layer_packer #(
    parameter int N_NEURONS = 64,
    parameter int OUT_BITS  = 1,
    parameter int CNT_W     = $clog2(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OUT_BITS-1:0]           M0,
`ifdef LAYER_PACKER_FRAMECHK_EN
    input  logic                          in_last,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] M1
`ifdef LAYER_PACKER_FRAMECHK_EN
    ,
    output logic                          frame_err
`endif
);

    localparam int W = N_NEURONS * OUT_BITS;

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_staging;
    logic [W-1:0]     r_slot [2];
    logic [1:0]       r_occ;
    logic             r_wp;
    logic             r_rp;

    logic             w_accept;
    logic             w_pop;
    logic             w_atEnd;
    logic             w_commit;
    logic [W-1:0]     w_merged;

    // Both handshake flags come straight from the occupancy register. This
    // keeps any combinational path from out_ready to in_ready out of the
    // design.
    assign in_ready  = (r_occ != 2'd2);
    assign out_valid = (r_occ != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_atEnd   = (r_cnt == CNT_W'(N_NEURONS - 1));

`ifdef LAYER_PACKER_FRAMECHK_EN
    assign w_commit = w_accept && (w_atEnd || in_last);
`else
    assign w_commit = w_accept && w_atEnd;
`endif

    // Staging contents with the current beat inserted. The commit copies this
    // value into a slot, so the final beat lands in the vector on the same
    // edge.
    always_comb begin
        w_merged = r_staging;
        for (int k = 0; k < N_NEURONS; k++) begin
            if (CNT_W'(k) == r_cnt) begin
                w_merged[k*OUT_BITS +: OUT_BITS] = M0;
            end
        end
    end

    // A popped slot still holds old data, so the output is forced to zero
    // while the buffer is empty.
    always_comb begin
        M1 = '0;
        if (r_occ != 2'd0) begin
            M1 = r_slot[r_rp];
        end
    end

    // Beat collection and commit into the write slot. Staging clears on a
    // commit, so a short (early-last) vector carries zeros in the neurons it
    // never received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_staging <= '0;
            r_wp      <= 1'b0;
            r_slot[0] <= '0;
            r_slot[1] <= '0;
        end else if (w_commit) begin
            r_slot[r_wp] <= w_merged;
            r_wp         <= ~r_wp;
            r_cnt        <= '0;
            r_staging    <= '0;
        end else if (w_accept) begin
            r_staging <= w_merged;
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    // Read pointer and occupancy. A commit and a pop on the same edge cancel
    // in occ, while both pointers still advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rp  <= 1'b0;
            r_occ <= 2'd0;
        end else begin
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            case ({w_commit, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef LAYER_PACKER_FRAMECHK_EN
    logic r_frameErr;

    // Sticky flag. It sets when in_last disagrees with the beat position,
    // which covers both an early last and a missing last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameErr <= 1'b0;
        end else if (w_accept && (in_last != w_atEnd)) begin
            r_frameErr <= 1'b1;
        end
    end

    assign frame_err = r_frameErr;
`endif

endmodule

// File: tb/tb_logicnets_layer_packer.sv
// ---------------------------------------------------------------------------
// tb_logicnets_layer_packer
//
// Randomised bench with a scoreboard. The driver feeds beats into a
// reference model. That model turns the accepted beats into whole vectors
// (a list of neuron values) and queues the expected vector. An independent
// monitor compares the DUT outputs against the queue on every falling edge.
// ---------------------------------------------------------------------------
module tb_logicnets_layer_packer;

   localparam int N  = 64;
   localparam int OB = 1;
   localparam int W  = N * OB;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [OB-1:0] M0;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  M1;
   logic          frame_err;

   int            errors;
   int            checks;
   bit            running;
   bit            randReady;

   // Reference model state: the neuron values received so far for the
   // vector being filled, the vectors committed but not yet consumed, and the
   // framing flag.
   logic [OB-1:0] beatList[$];
   logic [W-1:0]  expQ[$];
   bit            expErr;

   logicnets_layer_packer #(
      .N_NEURONS(N),
      .OUT_BITS (OB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .M0       (M0),
`ifdef LAYER_PACKER_FRAMECHK_EN
      .in_last  (in_last),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .M1       (M1)
`ifdef LAYER_PACKER_FRAMECHK_EN
      ,
      .frame_err(frame_err)
`endif
   );

   // 10 ns clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with the expected one and keep the counts.
   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model step for an accepted beat. A vector is complete after N neurons,
   // or, with framing checks, on an in_last. It then holds the received
   // neurons in order, with zeros for any neuron that never arrived.
   task automatic modelBeat(input logic [OB-1:0] val, input bit last);
      bit          done;
      int          pos;
      logic [W-1:0] vec;
      pos = beatList.size();
      beatList.push_back(val);
      done = (beatList.size() == N);
`ifdef LAYER_PACKER_FRAMECHK_EN
      if (last != (pos == N - 1)) expErr = 1'b1;
      done = done || last;
`else
      if (last && pos < 0) expErr = 1'b1;
`endif
      if (done) begin
         vec = '0;
         for (int k = 0; k < beatList.size(); k++) vec[k*OB +: OB] = beatList[k];
         expQ.push_back(vec);
         beatList.delete();
      end
   endtask

   // Present one beat and hold it until the DUT accepts it (bounded wait).
   // The task returns 1 ns after the accepting edge.
   task automatic applyStimulus(input logic [OB-1:0] val, input bit last);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      M0       = val;
      in_last  = last;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL beat_accept_timeout: in_ready stayed %b, required 1", in_ready);
      end
      @(posedge clk);
      if (ok) modelBeat(val, last);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Send a full vector, optionally with random idle cycles between beats.
   task automatic sendVector(input logic [W-1:0] vec, input bit gaps);
      for (int k = 0; k < N; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         applyStimulus(vec[k*OB +: OB], k == N - 1);
      end
   endtask

   // Let the consumer run until the scoreboard is empty.
   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 500 && expQ.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: %0d vectors pending, required 0", expQ.size());
      end
   endtask

   // Randomise out_ready between edges during the random phase.
   always @(posedge clk) begin
      #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: check the handshake flags against the model occupancy, check
   // M1 against the head of the scoreboard, and retire the head when the
   // consumer takes it on the coming edge.
   always @(negedge clk) begin
      if (running && !rst) begin
         checkOutput("in_ready", W'(in_ready), W'(expQ.size() != 2));
         checkOutput("out_valid", W'(out_valid), W'(expQ.size() != 0));
`ifdef LAYER_PACKER_FRAMECHK_EN
         checkOutput("frame_err", W'(frame_err), W'(expErr));
`endif
         if (expQ.size() == 0) begin
            checkOutput("M1_idle", M1, '0);
         end else begin
            checkOutput("M1_vector", M1, expQ[0]);
            if (out_ready) void'(expQ.pop_front());
         end
      end
   end

   initial begin
      logic [W-1:0] vec;
      logic [W-1:0] vecB;
      errors    = 0;
      checks    = 0;
      running   = 1'b0;
      randReady = 1'b0;
      expErr    = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      M0        = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", W'(out_valid), '0);
      checkOutput("reset_M1", M1, '0);
      checkOutput("reset_in_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1;
      rst     = 1'b0;
      running = 1'b1;

      // Single vector, bit k = k mod 2
      for (int k = 0; k < N; k++) vec[k] = 1'(k % 2);
      sendVector(vec, 1'b0);
      @(negedge clk);
      checkOutput("single_M1", M1, 64'hAAAA_AAAA_AAAA_AAAA);
      checkOutput("single_valid", W'(out_valid), W'(1));
      @(posedge clk);
      #1;
      drain();

      // Backpressure: two vectors fill the buffer, the third waits
      out_ready = 1'b0;
      sendVector('1, 1'b0);
      sendVector('0, 1'b0);
      @(negedge clk);
      checkOutput("bp_in_ready_low", W'(in_ready), '0);
      @(posedge clk);
      #1;
      fork
         sendVector('1, 1'b0);
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Simultaneous commit and pop with one vector buffered
      out_ready = 1'b0;
      vec  = {$urandom, $urandom};
      vecB = {$urandom, $urandom};
      sendVector(vec, 1'b0);
      for (int k = 0; k < N - 1; k++) applyStimulus(vecB[k*OB +: OB], 1'b0);
      out_ready = 1'b1;
      applyStimulus(vecB[(N-1)*OB +: OB], 1'b1);
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("simul_valid", W'(out_valid), W'(1));
      checkOutput("simul_M1", M1, vecB);
      checkOutput("simul_in_ready", W'(in_ready), W'(1));
      @(posedge clk);
      #1;
      drain();

      // Random phase: random data, gaps and consumer stalls
      randReady = 1'b1;
      for (int v = 0; v < 8; v++) sendVector({$urandom, $urandom}, 1'b1);
      randReady = 1'b0;
      #1;
      drain();

      // Reset mid-fill discards the partial vector
      for (int k = 0; k < 20; k++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      rst = 1'b1;
      beatList.delete();
      expQ.delete();
      expErr = 1'b0;
      @(negedge clk);
      checkOutput("midrst_valid", W'(out_valid), '0);
      checkOutput("midrst_M1", M1, '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sendVector('1, 1'b0);
      @(negedge clk);
      checkOutput("midrst_all_ones", M1, '1);
      @(posedge clk);
      #1;
      drain();

`ifdef LAYER_PACKER_FRAMECHK_EN
      // Early in_last on beat 9, then a correctly framed vector
      for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput("early_last_M1", M1, W'(64'h3FF));
      checkOutput("early_last_err", W'(frame_err), W'(1));
      @(posedge clk);
      #1;
      drain();
      sendVector({$urandom, $urandom}, 1'b0);
      drain();
      @(negedge clk);
      checkOutput("err_sticky", W'(frame_err), W'(1));
`endif

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
